seq_divider: RTL and testbench

- Sequential signed restoring divider; the inverse companion of boothMult.
- Takes a 2W-bit dividend and a W-bit divisor and returns a W-bit quotient and a W-bit remainder.
- Uses the same Start/Finish handshake as the multiplier, so control FSMs can drive either block interchangeably.
- Sits alongside boothMult in the lab5 datapath, e.g. to divide a product back down.

---
 rtl/seq_divider.sv | 195 +++++++++++++++++++
 tb/tb_seq_divider.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Sequential restoring divider: 2W-bit dividend / W-bit divisor -> W-bit quotient and remainder, Start/Finish handshake.
// Latency W+2 edges from the Start edge (2 edges on divide-by-zero or early overflow); Start ignored while busy.
// Optional build macro DIV_SIGN_SEL_EN adds SignedOp to select unsigned (0) or signed (1) operation.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               Resetn,
    input  logic               Start,
`ifdef DIV_SIGN_SEL_EN
    input  logic               SignedOp,
`endif
    input  logic [2*WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0]   Divisor,
    output logic [WIDTH-1:0]   Quotient,
    output logic [WIDTH-1:0]   Remainder,
    output logic               Finish,
    output logic               DivByZero,
    output logic               Overflow
);

    localparam int DW = 2 * WIDTH;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  CNT_LAST  = CW'(WIDTH - 1);
    localparam logic [WIDTH:0] POS_LIMIT = {2'b00, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH:0] NEG_LIMIT = {2'b01, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    state_t            state_q;
    logic [DW-1:0]     dvd_q;
    logic [WIDTH-1:0]  dvs_q;
    logic [WIDTH-1:0]  mag_dvs_q;
    logic [WIDTH-1:0]  rem_q;
    logic [WIDTH-1:0]  quo_q;
    logic [CW-1:0]     cnt_q;
    logic              sq_q;
    logic              sr_q;
    logic              dbz_pend_q;
    logic              ovf_pend_q;
    logic              op_signed;

`ifdef DIV_SIGN_SEL_EN
    logic              signed_q;
    assign op_signed = signed_q;
`else
    assign op_signed = 1'b1;
`endif

    // Operand magnitudes; the extra top bit lets the most-negative dividend negate without wrapping.
    logic              dvd_neg;
    logic              dvs_neg;
    logic [DW:0]       dvd_ext;
    logic [DW:0]       dvd_mag;
    logic [WIDTH:0]    dvs_ext;
    logic [WIDTH:0]    dvs_mag;
    logic [WIDTH-1:0]  dvd_upper;
    logic [WIDTH-1:0]  dvd_lower;
    logic              dvs_zero;
    logic              early_ovf;

    assign dvd_neg   = op_signed & dvd_q[DW-1];
    assign dvs_neg   = op_signed & dvs_q[WIDTH-1];
    assign dvd_ext   = {dvd_neg, dvd_q};
    assign dvs_ext   = {dvs_neg, dvs_q};
    assign dvd_mag   = dvd_neg ? -dvd_ext : dvd_ext;
    assign dvs_mag   = dvs_neg ? -dvs_ext : dvs_ext;
    assign dvd_upper = dvd_mag[DW-1:WIDTH];
    assign dvd_lower = dvd_mag[WIDTH-1:0];
    assign dvs_zero  = (dvs_q == '0);
    assign early_ovf = (dvd_upper >= dvs_mag[WIDTH-1:0]);

    // One restoring step: partial remainder stays below |Divisor|, so W bits hold it between steps.
    logic [WIDTH:0]    shifted;
    logic [WIDTH:0]    diff;
    logic              trial_ge;
    logic [WIDTH-1:0]  rem_d;
    logic [WIDTH-1:0]  quo_d;
    logic [CW-1:0]     cnt_d;

    assign shifted  = {rem_q, quo_q[WIDTH-1]};
    assign diff     = shifted - {1'b0, mag_dvs_q};
    assign trial_ge = (shifted >= {1'b0, mag_dvs_q});
    assign rem_d    = trial_ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign quo_d    = {quo_q[WIDTH-2:0], trial_ge};
    assign cnt_d    = cnt_q - CW'(1);

    logic              fix_ovf;
    logic [WIDTH-1:0]  quo_signed;
    logic [WIDTH-1:0]  rem_signed;

    assign fix_ovf    = op_signed & (sq_q ? ({1'b0, quo_q} > NEG_LIMIT)
                                          : ({1'b0, quo_q} > POS_LIMIT));
    assign quo_signed = sq_q ? -quo_q : quo_q;
    assign rem_signed = sr_q ? -rem_q : rem_q;

    logic unused_bits;
    assign unused_bits = ^{dvd_mag[DW], dvs_mag[WIDTH], diff[WIDTH]};

    always_ff @(posedge clk or negedge Resetn) begin
        if (!Resetn) begin
            state_q    <= S_IDLE;
            dvd_q      <= '0;
            dvs_q      <= '0;
            mag_dvs_q  <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            cnt_q      <= '0;
            sq_q       <= 1'b0;
            sr_q       <= 1'b0;
            dbz_pend_q <= 1'b0;
            ovf_pend_q <= 1'b0;
`ifdef DIV_SIGN_SEL_EN
            signed_q   <= 1'b0;
`endif
            Quotient   <= '0;
            Remainder  <= '0;
            Finish     <= 1'b0;
            DivByZero  <= 1'b0;
            Overflow   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (Start) begin
                        dvd_q    <= Dividend;
                        dvs_q    <= Divisor;
`ifdef DIV_SIGN_SEL_EN
                        signed_q <= SignedOp;
`endif
                        state_q  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    sq_q       <= dvd_neg ^ dvs_neg;
                    sr_q       <= dvd_neg;
                    mag_dvs_q  <= dvs_mag[WIDTH-1:0];
                    rem_q      <= dvd_upper;
                    quo_q      <= dvd_lower;
                    cnt_q      <= CNT_LAST;
                    dbz_pend_q <= dvs_zero;
                    ovf_pend_q <= !dvs_zero && early_ovf;
                    // Early exits pass through FIX so every result is published from a single place.
                    state_q    <= (dvs_zero || early_ovf) ? S_FIX : S_ITER;
                end
                S_ITER: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_d;
                    if (cnt_q == '0) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    Finish  <= 1'b1;
                    state_q <= S_DONE;
                    if (dbz_pend_q) begin
                        DivByZero <= 1'b1;
                        Quotient  <= '0;
                        Remainder <= '0;
                    end else if (ovf_pend_q || fix_ovf) begin
                        Overflow  <= 1'b1;
                        Quotient  <= '0;
                        Remainder <= '0;
                    end else begin
                        Quotient  <= quo_signed;
                        Remainder <= rem_signed;
                    end
                end
                S_DONE: begin
                    if (Start) begin
                        dvd_q     <= Dividend;
                        dvs_q     <= Divisor;
`ifdef DIV_SIGN_SEL_EN
                        signed_q  <= SignedOp;
`endif
                        Finish    <= 1'b0;
                        DivByZero <= 1'b0;
                        Overflow  <= 1'b0;
                        state_q   <= S_LOAD;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: integer-arithmetic reference model checked every cycle, plus literal expectations per operation.
module tb_seq_divider;

    logic        clk;
    logic        Resetn;
    logic        Start;
    logic [15:0] Dividend;
    logic [7:0]  Divisor;
    logic [7:0]  Quotient;
    logic [7:0]  Remainder;
    logic        Finish;
    logic        DivByZero;
    logic        Overflow;

    seq_divider #(.WIDTH(8)) dut (
        .clk       (clk),
        .Resetn    (Resetn),
        .Start     (Start),
`ifdef DIV_SIGN_SEL_EN
        .SignedOp  (1'b1),
`endif
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .Finish    (Finish),
        .DivByZero (DivByZero),
        .Overflow  (Overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errs   = 0;

    // Model state, written only by the stimulus process.
    logic       mdl_active = 1'b0;
    int         start_cyc  = 0;
    int         mdl_lat    = 10;
    logic [7:0] mdl_q = 8'h00, mdl_r = 8'h00, mdl_prev_q = 8'h00, mdl_prev_r = 8'h00;
    logic       mdl_dbz = 1'b0, mdl_ovf = 1'b0;
    int         lit_lat = 10;
    logic [7:0] lit_q = 8'h00, lit_r = 8'h00;
    logic       lit_dbz = 1'b0, lit_ovf = 1'b0;

    // Reference: plain signed integer division (truncating), remainder takes the dividend's sign.
    function automatic void model(input logic signed [15:0] a, input logic signed [7:0] b,
                                  output logic [7:0] q, output logic [7:0] r,
                                  output logic dbz, output logic ovf, output int lat);
        int ai, bi, qi, ri;
        ai = a;
        bi = b;
        q = 8'h00; r = 8'h00; dbz = 1'b0; ovf = 1'b0; lat = 10;
        if (bi == 0) begin
            dbz = 1'b1;
            lat = 2;
        end else begin
            qi = ai / bi;
            ri = ai % bi;
            if (qi >= 256 || qi <= -256) lat = 2;
            if (qi > 127 || qi < -128) begin
                ovf = 1'b1;
            end else begin
                q = qi[7:0];
                r = ri[7:0];
            end
        end
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errs++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : compare
        int e;
        if (!Resetn) begin
            chk("rst_finish", Finish, 0);
            chk("rst_quotient", Quotient, 0);
            chk("rst_remainder", Remainder, 0);
            chk("rst_dbz", DivByZero, 0);
            chk("rst_ovf", Overflow, 0);
        end else if (mdl_active) begin
            e = cyc - start_cyc;
            if (e >= 0) begin
                if (e < mdl_lat) begin
                    chk("busy_finish", Finish, 0);
                    chk("busy_hold_quotient", Quotient, mdl_prev_q);
                    chk("busy_hold_remainder", Remainder, mdl_prev_r);
                    chk("busy_dbz", DivByZero, 0);
                    chk("busy_ovf", Overflow, 0);
                end else begin
                    chk("done_finish", Finish, 1);
                    chk("done_quotient", Quotient, mdl_q);
                    chk("done_remainder", Remainder, mdl_r);
                    chk("done_dbz", DivByZero, mdl_dbz);
                    chk("done_ovf", Overflow, mdl_ovf);
                end
                if (e == lit_lat - 1) chk("lit_finish_not_early", Finish, 0);
                if (e == lit_lat) begin
                    chk("lit_finish", Finish, 1);
                    chk("lit_quotient", Quotient, lit_q);
                    chk("lit_remainder", Remainder, lit_r);
                    chk("lit_dbz", DivByZero, lit_dbz);
                    chk("lit_ovf", Overflow, lit_ovf);
                end
            end
        end
    end

    // poke_at: re-pulse Start with 50/5 mid-operation; rst_at: assert reset mid-operation.
    task automatic run_op(input logic [15:0] a, input logic [7:0] b,
                          input logic [7:0] lq, input logic [7:0] lr,
                          input logic ldbz, input logic lovf, input int llat,
                          input int poke_at, input int rst_at);
        logic [7:0] q, r;
        logic dz, ov;
        int lat;
        model(a, b, q, r, dz, ov, lat);
        @(posedge clk); #2;
        mdl_prev_q = mdl_q;  mdl_prev_r = mdl_r;
        mdl_q = q;  mdl_r = r;  mdl_dbz = dz;  mdl_ovf = ov;  mdl_lat = lat;
        lit_q = lq; lit_r = lr; lit_dbz = ldbz; lit_ovf = lovf; lit_lat = llat;
        Dividend = a;
        Divisor = b;
        Start = 1'b1;
        start_cyc = cyc + 1;
        mdl_active = 1'b1;
        @(posedge clk); #2;
        Start = 1'b0;
        Dividend = 16'($urandom);
        Divisor = 8'($urandom);
        for (int i = 1; i < 60; i++) begin
            if (i == poke_at) begin
                Start = 1'b1;
                Dividend = 16'd50;
                Divisor = 8'd5;
            end else begin
                Start = 1'b0;
            end
            if (rst_at > 0 && i == rst_at) begin
                Resetn = 1'b0;
                mdl_active = 1'b0;
                mdl_q = 8'h00;
                mdl_r = 8'h00;
            end
            if (rst_at > 0 && i == rst_at + 2) begin
                Resetn = 1'b1;
                break;
            end
            if (rst_at == 0 && Finish && i > poke_at + 1) break;
            @(posedge clk); #2;
        end
        Start = 1'b0;
    endtask

    initial begin
        Resetn = 1'b1;
        Start = 1'b0;
        Dividend = 16'h0000;
        Divisor = 8'h00;
        #1 Resetn = 1'b0;
        repeat (3) @(posedge clk);
        #2 Resetn = 1'b1;

        //      dividend  divisor  quot   rem    dbz   ovf   lat poke rst
        run_op(16'd100,   8'd7,    8'h0E, 8'h02, 1'b0, 1'b0, 10, 0, 0);
        run_op(16'hFF9C,  8'd7,    8'hF2, 8'hFE, 1'b0, 1'b0, 10, 0, 0);
        run_op(16'd100,   8'hF9,   8'hF2, 8'h02, 1'b0, 1'b0, 10, 0, 0);
        run_op(16'd1234,  8'd0,    8'h00, 8'h00, 1'b1, 1'b0, 2,  0, 0);
        run_op(16'd16384, 8'd1,    8'h00, 8'h00, 1'b0, 1'b1, 2,  0, 0);
        run_op(16'd128,   8'd1,    8'h00, 8'h00, 1'b0, 1'b1, 10, 0, 0);
        run_op(16'hFF80,  8'd1,    8'h80, 8'h00, 1'b0, 1'b0, 10, 0, 0);
        run_op(16'h8000,  8'h80,   8'h00, 8'h00, 1'b0, 1'b1, 2,  0, 0);
        run_op(16'h8001,  8'h80,   8'h00, 8'h00, 1'b0, 1'b1, 10, 0, 0);
        run_op(16'hC000,  8'h80,   8'h00, 8'h00, 1'b0, 1'b1, 10, 0, 0);
        run_op(16'h4000,  8'h80,   8'h80, 8'h00, 1'b0, 1'b0, 10, 0, 0);
        run_op(16'd0,     8'd5,    8'h00, 8'h00, 1'b0, 1'b0, 10, 0, 0);
        run_op(16'hFFFF,  8'h80,   8'h00, 8'hFF, 1'b0, 1'b0, 10, 0, 0);
        run_op(16'd32767, 8'd127,  8'h00, 8'h00, 1'b0, 1'b1, 2,  0, 0);
        run_op(16'd1000,  8'hE7,   8'hD8, 8'h00, 1'b0, 1'b0, 10, 0, 0);

        // Async reset mid-operation, then the divider must still work from IDLE.
        run_op(16'd100,   8'd7,    8'h0E, 8'h02, 1'b0, 1'b0, 10, 0, 0);
        run_op(16'd300,   8'd9,    8'h21, 8'h03, 1'b0, 1'b0, 10, 0, 5);
        run_op(16'd100,   8'd7,    8'h0E, 8'h02, 1'b0, 1'b0, 10, 0, 0);

        // Start while busy is ignored; Start in DONE launches the next operation.
        run_op(16'd100,   8'd7,    8'h0E, 8'h02, 1'b0, 1'b0, 10, 4, 0);
        run_op(16'd50,    8'd5,    8'h0A, 8'h00, 1'b0, 1'b0, 10, 0, 0);

        repeat (3) @(posedge clk);
        #2 mdl_active = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errs, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
